// File: rtl/motor_move_sequencer.sv
// Single-axis move sequencer for six stepper motors: validates a one-hot motor select
// and BCD target, then emits timed Dir/Step pulses while tracking every motor position.
module motor_move_sequencer #(
   parameter int STEP_PERIOD = 50000,
   parameter int PULSE_W     = 100,
   parameter int DIR_SETUP   = 10
) (
   input  logic       sysclk,
   input  logic       INIT,
   input  logic       Enter,
   input  logic [5:0] Motor,
   input  logic [3:0] TValue0,
   input  logic [3:0] TValue1,
   input  logic [3:0] TValue2,
   output logic [5:0] Step,
   output logic [5:0] Dir,
   output logic       Busy,
   output logic       Done,
   output logic       Err,
   output logic [9:0] CurPos,
   output logic [2:0] CurSel
);

   localparam int CNT_MAX = (STEP_PERIOD > DIR_SETUP) ? STEP_PERIOD : DIR_SETUP;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam logic [CW-1:0] SETUP_LAST = CW'(DIR_SETUP - 1);
   localparam logic [CW-1:0] HI_LAST    = CW'(PULSE_W - 1);
   localparam logic [CW-1:0] LO_LAST    = CW'(STEP_PERIOD - PULSE_W - 1);

   typedef enum logic [2:0] {IDLE, LOAD, SETUP, PULSE_HI, PULSE_LO, FINISH} state_t;

   state_t        state, next_state;
   logic          enter_q, start_q;
   logic [5:0]    motor_l;
   logic [3:0]    dig_h, dig_t, dig_u;
   logic [9:0]    pos [6];
   logic [9:0]    remaining;
   logic [CW-1:0] cnt;

   logic [2:0]    load_idx;
   logic [9:0]    target, load_pos, distance, step_pos;
   logic          req_ok;

   // NOTE: every signal written in a combinational block gets a default first, so no latch is inferred.
   always_comb begin
      load_idx = '0;
      for (int i = 0; i < 6; i++) begin
         if (motor_l[i]) load_idx = 3'(i);
      end
      target   = 10'(dig_h) * 10'd100 + 10'(dig_t) * 10'd10 + 10'(dig_u);
      load_pos = pos[load_idx];
      distance = (target > load_pos) ? target - load_pos : load_pos - target;
      req_ok   = (motor_l != 6'd0) && ((motor_l & (motor_l - 6'd1)) == 6'd0) &&
                 (dig_h <= 4'd9) && (dig_t <= 4'd9) && (dig_u <= 4'd9);
      step_pos = Dir[CurSel] ? pos[CurSel] + 10'd1 : pos[CurSel] - 10'd1;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:     if (start_q) next_state = LOAD;
         LOAD:     next_state = (!req_ok || distance == 10'd0) ? FINISH : SETUP;
         SETUP:    if (cnt == SETUP_LAST) next_state = PULSE_HI;
         PULSE_HI: if (cnt == HI_LAST) next_state = PULSE_LO;
         PULSE_LO: if (cnt == LO_LAST) next_state = (remaining == 10'd0) ? FINISH : PULSE_HI;
         FINISH:   next_state = IDLE;
         default:  next_state = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
   always_ff @(posedge sysclk) begin
      if (INIT) begin
         state     <= IDLE;
         enter_q   <= 1'b0;
         start_q   <= 1'b0;
         motor_l   <= '0;
         dig_h     <= '0;
         dig_t     <= '0;
         dig_u     <= '0;
         remaining <= '0;
         cnt       <= '0;
         Step      <= '0;
         Dir       <= '0;
         Busy      <= 1'b0;
         Done      <= 1'b0;
         Err       <= 1'b0;
         CurPos    <= '0;
         CurSel    <= '0;
         // NOTE: the position store is architectural state and must read 0 after reset, so it is reset explicitly.
         for (int i = 0; i < 6; i++) pos[i] <= '0;
      end else begin
         enter_q <= Enter;
         start_q <= Enter & ~enter_q;
         state   <= next_state;
         cnt     <= (next_state != state || state == IDLE) ? '0 : cnt + CW'(1);
         Busy    <= (next_state != IDLE);
         Done    <= (next_state == FINISH);
         Err     <= (state == LOAD) && !req_ok;
         // CurSel is already valid here: PULSE_HI is never entered directly from LOAD.
         Step    <= (next_state == PULSE_HI) ? (6'b000001 << CurSel) : 6'b000000;

         case (state)
            IDLE: begin
               if (start_q) begin
                  motor_l <= Motor;
                  dig_h   <= TValue0;
                  dig_t   <= TValue1;
                  dig_u   <= TValue2;
               end
            end
            LOAD: begin
               if (req_ok) begin
                  CurSel    <= load_idx;
                  CurPos    <= load_pos;
                  remaining <= distance;
                  if (distance != 10'd0) Dir[load_idx] <= (target > load_pos);
               end
            end
            PULSE_HI: begin
               if (cnt == HI_LAST) begin
                  pos[CurSel] <= step_pos;
                  CurPos      <= step_pos;
                  remaining   <= remaining - 10'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_motor_move_sequencer.sv
// Randomized scoreboard bench for motor_move_sequencer: a position/direction model predicts
// each move's completion, and a monitor checks every Done and every step against it.
module tb_motor_move_sequencer;

   localparam int STEP_PERIOD = 4;
   localparam int PULSE_W     = 2;
   localparam int DIR_SETUP   = 1;

   logic       clk = 1'b0;
   logic       INIT = 1'b1;
   logic       Enter = 1'b0;
   logic [5:0] Motor = '0;
   logic [3:0] TValue0 = '0, TValue1 = '0, TValue2 = '0;
   logic [5:0] Step, Dir;
   logic       Busy, Done, Err;
   logic [9:0] CurPos;
   logic [2:0] CurSel;

   motor_move_sequencer #(
      .STEP_PERIOD(STEP_PERIOD),
      .PULSE_W    (PULSE_W),
      .DIR_SETUP  (DIR_SETUP)
   ) dut (
      .sysclk (clk),
      .INIT   (INIT),
      .Enter  (Enter),
      .Motor  (Motor),
      .TValue0(TValue0),
      .TValue1(TValue1),
      .TValue2(TValue2),
      .Step   (Step),
      .Dir    (Dir),
      .Busy   (Busy),
      .Done   (Done),
      .Err    (Err),
      .CurPos (CurPos),
      .CurSel (CurSel)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int         done_cyc;
      int         first_cyc;
      int         n;
      int         idx;
      int         start;
      bit         up;
      bit         err;
      int         pos;
      int         sel;
      logic [5:0] dir;
   } exp_t;

   exp_t sb_q[$];

   int vectors = 0;
   int miscompares = 0;

   task automatic check(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: absolute motor positions, direction bits, last selection.
   int         model_pos [6];
   logic [5:0] model_dir = '0;
   int         model_sel = 0;

   task automatic model_reset();
      for (int i = 0; i < 6; i++) model_pos[i] = 0;
      model_dir = '0;
      model_sel = 0;
   endtask

   // Monitor: counts step pulses and checks each completion against the queue head.
   int   hi_cnt = 0, stray_cnt = 0, steps_seen = 0, first_seen = -1;
   bit   prev_hi = 0, cur_hi = 0, busy_low_due = 0;
   int   exp_step_pos;
   exp_t mon_e;

   always @(posedge clk) begin
      #1;
      if (INIT) begin
         hi_cnt = 0; stray_cnt = 0; steps_seen = 0; first_seen = -1;
         prev_hi = 0; busy_low_due = 0;
      end else begin
         if (busy_low_due) begin
            check("busy_after_done", Busy, 0);
            busy_low_due = 0;
         end
         cur_hi = 0;
         if (sb_q.size() > 0) cur_hi = Step[sb_q[0].idx];
         if (Step != 6'd0 && !(sb_q.size() > 0 && Step == (6'b000001 << sb_q[0].idx)))
            stray_cnt++;
         if (cur_hi) begin
            if (hi_cnt == 0) first_seen = cyc;
            hi_cnt++;
         end
         if (prev_hi && !cur_hi && sb_q.size() > 0) begin
            steps_seen++;
            exp_step_pos = sb_q[0].up ? sb_q[0].start + steps_seen : sb_q[0].start - steps_seen;
            check("curpos_after_step", CurPos, exp_step_pos);
         end
         prev_hi = cur_hi;
         if (Done || Err) begin
            if (Err) check("err_with_done", Done, 1);
            if (sb_q.size() == 0) begin
               check("unexpected_done", sb_q.size(), 1);
            end else begin
               mon_e = sb_q.pop_front();
               check("done_cycle", cyc, mon_e.done_cyc);
               check("err", Err, mon_e.err);
               check("busy_at_done", Busy, 1);
               check("curpos", CurPos, mon_e.pos);
               check("cursel", CurSel, mon_e.sel);
               check("dir", Dir, mon_e.dir);
               check("steps", steps_seen, mon_e.n);
               check("step_high_cycles", hi_cnt, mon_e.n * PULSE_W);
               check("first_step_cycle", first_seen, mon_e.first_cyc);
               check("stray_step", stray_cnt, 0);
               hi_cnt = 0; stray_cnt = 0; steps_seen = 0; first_seen = -1;
               prev_hi = 0; busy_low_due = 1;
            end
         end
      end
   end

   // Issue one request at the current negedge and wait for its completion.
   // retrig re-raises Enter mid-move; abort_off > 0 asserts INIT that many cycles after Enter.
   task automatic do_move(input logic [5:0] m, input logic [3:0] h, input logic [3:0] t,
                          input logic [3:0] u, input bit retrig, input int abort_off);
      exp_t e;
      int   e_cyc, budget, off, idx, tgt, n;
      bit   valid, finished;
      Enter = 1'b1; Motor = m; TValue0 = h; TValue1 = t; TValue2 = u;
      e_cyc = cyc;
      valid = (m != 6'd0) && ($countones(m) == 1) && (h <= 4'd9) && (t <= 4'd9) && (u <= 4'd9);
      e.err = !valid; e.n = 0; e.idx = 0; e.start = 0; e.up = 0;
      if (valid) begin
         idx = 0;
         for (int i = 0; i < 6; i++) if (m[i]) idx = i;
         tgt = int'(h) * 100 + int'(t) * 10 + int'(u);
         n = (tgt > model_pos[idx]) ? tgt - model_pos[idx] : model_pos[idx] - tgt;
         e.n = n; e.idx = idx; e.start = model_pos[idx]; e.up = (tgt > model_pos[idx]);
         if (n > 0) model_dir[idx] = e.up;
         model_pos[idx] = tgt;
         model_sel = idx;
      end
      e.done_cyc  = (e.n == 0) ? e_cyc + 3 : e_cyc + 2 + DIR_SETUP + e.n * STEP_PERIOD + 1;
      e.first_cyc = (e.n == 0) ? -1 : e_cyc + 2 + DIR_SETUP + 1;
      e.pos = model_pos[model_sel];
      e.sel = model_sel;
      e.dir = model_dir;
      sb_q.push_back(e);
      budget = e.done_cyc - e_cyc + 10;
      finished = 0;
      for (int k = 0; k < budget && !finished; k++) begin
         @(negedge clk);
         off = cyc - e_cyc;
         if (off == 2) begin
            Enter = 1'b0;
            Motor = 6'($urandom); TValue0 = 4'($urandom); TValue1 = 4'($urandom); TValue2 = 4'($urandom);
         end
         if (retrig && off == 5) begin Enter = 1'b1; Motor = 6'b000010; TValue2 = 4'd7; end
         if (retrig && off == 7) Enter = 1'b0;
         if (abort_off > 0) begin
            if (off == abort_off) begin
               INIT = 1'b1;
               sb_q.delete();
               model_reset();
            end else if (off == abort_off + 1) begin
               check("init_step", Step, 0);
               check("init_busy", Busy, 0);
               check("init_done", Done, 0);
               check("init_curpos", CurPos, 0);
               check("init_cursel", CurSel, 0);
               check("init_dir", Dir, 0);
               INIT = 1'b0;
               finished = 1;
            end
         end else if (sb_q.size() == 0) begin
            finished = 1;
         end
      end
      if (!finished) begin
         check("move_done_timeout", sb_q.size(), 0);
         sb_q.delete();
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      int         r, idx, tgt, which, a, b;
      logic [5:0] m;
      logic [3:0] h, t, u;
      model_reset();
      INIT = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_step", Step, 0);
      check("rst_dir", Dir, 0);
      check("rst_busy", Busy, 0);
      check("rst_done", Done, 0);
      check("rst_err", Err, 0);
      check("rst_curpos", CurPos, 0);
      check("rst_cursel", CurSel, 0);
      INIT = 1'b0;

      do_move(6'b000001, 4'd0, 4'd0, 4'd3, 0, 0);
      do_move(6'b000001, 4'd0, 4'd0, 4'd1, 0, 0);
      do_move(6'b000001, 4'd0, 4'd0, 4'd1, 0, 0);
      do_move(6'b000101, 4'd0, 4'd0, 4'd2, 0, 0);
      do_move(6'b000001, 4'd0, 4'hA, 4'd2, 0, 0);
      do_move(6'b000000, 4'd0, 4'd0, 4'd2, 0, 0);
      do_move(6'b100000, 4'd0, 4'd0, 4'd5, 1, 0);
      do_move(6'b000010, 4'd9, 4'd9, 4'd9, 0, 0);
      do_move(6'b000010, 4'd9, 4'd9, 4'd0, 0, 0);
      repeat (2) @(negedge clk);
      do_move(6'b000100, 4'd0, 4'd1, 4'd0, 0, 8);
      do_move(6'b000001, 4'd0, 4'd0, 4'd3, 0, 0);

      for (int k = 0; k < 40; k++) begin
         r = $urandom_range(0, 9);
         if (r < 8) begin
            idx = $urandom_range(0, 5);
            m = 6'b000001 << idx;
            tgt = model_pos[idx] + $urandom_range(0, 24) - 12;
            if (tgt < 0) tgt = 0;
            if (tgt > 999) tgt = 999;
         end else if (r == 8) begin
            m = 6'b000000;
            tgt = $urandom_range(0, 999);
         end else begin
            a = $urandom_range(0, 5);
            b = (a + $urandom_range(1, 5)) % 6;
            m = (6'b000001 << a) | (6'b000001 << b);
            tgt = $urandom_range(0, 999);
         end
         h = 4'(tgt / 100); t = 4'((tgt / 10) % 10); u = 4'(tgt % 10);
         if ($urandom_range(0, 7) == 0) begin
            which = $urandom_range(0, 2);
            if (which == 0) h = 4'($urandom_range(10, 15));
            else if (which == 1) t = 4'($urandom_range(10, 15));
            else u = 4'($urandom_range(10, 15));
         end
         do_move(m, h, t, u, 0, 0);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      repeat (4) @(negedge clk);
      check("queue_drained", sb_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
